// File: rtl/contador_programa.sv
// Program counter / fetch sequencer feeding the instruction memory address.
// Sequences sequential fetch, stall, absolute jump, signed relative branch,
// halt/resume and out-of-range detection. All outputs are registered.
module contador_programa #(
    parameter int                ADDR_W     = 5,
    parameter int                OFF_W      = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter bit                WRAP_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] direinstru,
    output logic              fetch_valid,
    output logic              halted,
    output logic              fault
);

    // Wide enough that neither a negative result nor a carry past the top
    // address can be lost before the range check.
    localparam int SUM_W = ADDR_W + OFF_W + 1;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] dir_nx;
    logic              fv_nx;
    logic              halted_nx;
    logic              fault_nx;

    logic [SUM_W-1:0]  addend;
    logic [SUM_W-1:0]  target;
    logic              out_of_range;
    logic              range_fault;

    // Target address: sign-extended branch offset in RUN when branching,
    // otherwise +1 (sequential fetch and resume both advance by one word).
    always_comb begin
        if (state == RUN && branch) begin
            addend = {{(ADDR_W+1){branch_off[OFF_W-1]}}, branch_off};
        end else begin
            addend = {{(SUM_W-1){1'b0}}, 1'b1};
        end
        target       = {{(OFF_W+1){1'b0}}, direinstru} + addend;
        // Negative (sign bit) or beyond the top address (any bit above ADDR_W).
        out_of_range = target[SUM_W-1] | (|target[SUM_W-2:ADDR_W]);
        range_fault  = !WRAP_EN && out_of_range;
    end

    // Next-state and next-output decode; every target defaulted to "hold".
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        state_nx  = state;
        dir_nx    = direinstru;
        fv_nx     = fetch_valid;
        halted_nx = halted;
        fault_nx  = fault;
        unique case (state)
            BOOT: begin
                // Memory load cycle: controls ignored, address held.
                state_nx  = RUN;
                fv_nx     = 1'b1;
                halted_nx = 1'b0;
            end
            RUN: begin
                if (halt) begin
                    state_nx  = HALT;
                    fv_nx     = 1'b0;
                    halted_nx = 1'b1;
                end else if (stall) begin
                    // Any jump/branch seen with stall is dropped, not queued.
                    fv_nx = 1'b0;
                end else if (jump) begin
                    dir_nx = jump_addr;
                    fv_nx  = 1'b1;
                end else if (range_fault) begin
                    state_nx  = HALT;
                    fv_nx     = 1'b0;
                    halted_nx = 1'b1;
                    fault_nx  = 1'b1;
                end else begin
                    dir_nx = target[ADDR_W-1:0];
                    fv_nx  = 1'b1;
                end
            end
            HALT: begin
                fv_nx     = 1'b0;
                halted_nx = 1'b1;
                if (resume && !halt) begin
                    if (fault) begin
                        // Recover from a fault by restarting the program.
                        state_nx  = BOOT;
                        dir_nx    = START_ADDR;
                        halted_nx = 1'b0;
                        fault_nx  = 1'b0;
                    end else if (range_fault) begin
                        // Resuming past the top address faults again.
                        fault_nx = 1'b1;
                    end else begin
                        // Held instruction was already consumed: skip it.
                        state_nx  = RUN;
                        dir_nx    = target[ADDR_W-1:0];
                        fv_nx     = 1'b1;
                        halted_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx  = BOOT;
                dir_nx    = START_ADDR;
                fv_nx     = 1'b0;
                halted_nx = 1'b0;
                fault_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values; the reset sits in the sensitivity list to act
    // without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            direinstru  <= START_ADDR;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            direinstru  <= dir_nx;
            fetch_valid <= fv_nx;
            halted      <= halted_nx;
            fault       <= fault_nx;
        end
    end

endmodule

// File: tb/tb_contador_programa.sv
// Directed bench for contador_programa: one wrapping and one faulting instance
// share stimulus; a vector table covers the main sequence, followed by
// hand-written fault-recovery and asynchronous-reset sequences.
module tb_contador_programa;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [15:0] branch_off;
    logic        jump;
    logic [4:0]  jump_addr;
    logic        halt;
    logic        resume;

    logic [4:0]  dir_w, dir_n;
    logic        fv_w, fv_n, hl_w, hl_n, ft_w, ft_n;
    logic [7:0]  obs_w, obs_n;

    int checks   = 0;
    int failures = 0;

    assign obs_w = {dir_w, fv_w, hl_w, ft_w};
    assign obs_n = {dir_n, fv_n, hl_n, ft_n};

    contador_programa #(.ADDR_W(5), .OFF_W(16), .START_ADDR(5'd0), .WRAP_EN(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_off(branch_off), .jump(jump), .jump_addr(jump_addr),
        .halt(halt), .resume(resume), .direinstru(dir_w),
        .fetch_valid(fv_w), .halted(hl_w), .fault(ft_w)
    );

    contador_programa #(.ADDR_W(5), .OFF_W(16), .START_ADDR(5'd0), .WRAP_EN(1'b0)) dut_nowrap (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_off(branch_off), .jump(jump), .jump_addr(jump_addr),
        .halt(halt), .resume(resume), .direinstru(dir_n),
        .fetch_valid(fv_n), .halted(hl_n), .fault(ft_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [15:0] off;
        logic        jp;
        logic [4:0]  ja;
        logic        hl;
        logic        rs;
        logic [7:0]  exp_w;
        logic [7:0]  exp_n;
    } vec_t;

    function automatic logic [7:0] e(input logic [4:0] d, input logic v,
                                     input logic h, input logic f);
        return {d, v, h, f};
    endfunction

    function automatic vec_t mk(input logic st, input logic br, input logic [15:0] off,
                                input logic jp, input logic [4:0] ja, input logic hl,
                                input logic rs, input logic [7:0] ew, input logic [7:0] en);
        vec_t v;
        v.st = st; v.br = br; v.off = off; v.jp = jp; v.ja = ja;
        v.hl = hl; v.rs = rs; v.exp_w = ew; v.exp_n = en;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got dir=%0d fv=%b halted=%b fault=%b, want dir=%0d fv=%b halted=%b fault=%b",
                     name, act[7:3], act[2], act[1], act[0], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic [15:0] off,
                         input logic jp, input logic [4:0] ja, input logic hl, input logic rs);
        stall = st; branch = br; branch_off = off; jump = jp;
        jump_addr = ja; halt = hl; resume = rs;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t vec[23];

    initial begin
        // halt  stall branch jump: column order st br off jp ja hl rs
        vec[0]  = mk(0,0,16'h0000,0,5'd0 ,0,0, e(0 ,1,0,0), e(0 ,1,0,0)); // BOOT -> RUN
        vec[1]  = mk(0,0,16'h0000,0,5'd0 ,0,0, e(1 ,1,0,0), e(1 ,1,0,0));
        vec[2]  = mk(0,0,16'h0000,0,5'd0 ,0,0, e(2 ,1,0,0), e(2 ,1,0,0));
        vec[3]  = mk(0,0,16'h0000,0,5'd0 ,0,0, e(3 ,1,0,0), e(3 ,1,0,0));
        vec[4]  = mk(0,1,16'h0002,0,5'd0 ,0,0, e(5 ,1,0,0), e(5 ,1,0,0)); // 3 + 2
        vec[5]  = mk(0,1,16'hFFFE,0,5'd0 ,0,0, e(3 ,1,0,0), e(3 ,1,0,0)); // 5 - 2
        vec[6]  = mk(0,0,16'h0000,0,5'd0 ,0,0, e(4 ,1,0,0), e(4 ,1,0,0));
        vec[7]  = mk(1,1,16'h0002,1,5'd20,0,0, e(4 ,0,0,0), e(4 ,0,0,0)); // stall wins
        vec[8]  = mk(0,1,16'h0002,1,5'd20,0,0, e(20,1,0,0), e(20,1,0,0)); // jump beats branch
        vec[9]  = mk(0,0,16'h0000,1,5'd6 ,0,0, e(6 ,1,0,0), e(6 ,1,0,0));
        vec[10] = mk(0,0,16'h0000,0,5'd0 ,0,0, e(7 ,1,0,0), e(7 ,1,0,0));
        vec[11] = mk(0,0,16'h0000,0,5'd0 ,1,0, e(7 ,0,1,0), e(7 ,0,1,0)); // halt
        vec[12] = mk(0,0,16'h0000,0,5'd0 ,0,0, e(7 ,0,1,0), e(7 ,0,1,0));
        vec[13] = mk(0,0,16'h0000,0,5'd0 ,1,1, e(7 ,0,1,0), e(7 ,0,1,0)); // halt+resume stays
        vec[14] = mk(0,0,16'h0000,0,5'd0 ,0,1, e(8 ,1,0,0), e(8 ,1,0,0)); // resume -> +1
        vec[15] = mk(0,0,16'h0000,1,5'd30,0,0, e(30,1,0,0), e(30,1,0,0));
        vec[16] = mk(0,0,16'h0000,0,5'd0 ,0,0, e(31,1,0,0), e(31,1,0,0));
        vec[17] = mk(0,0,16'h0000,0,5'd0 ,0,0, e(0 ,1,0,0), e(31,0,1,1)); // wrap vs fault
        vec[18] = mk(0,0,16'h0000,0,5'd0 ,0,0, e(1 ,1,0,0), e(31,0,1,1));
        vec[19] = mk(0,1,16'hFFFF,0,5'd0 ,0,0, e(0 ,1,0,0), e(31,0,1,1)); // 1 - 1
        vec[20] = mk(0,1,16'hFFFF,0,5'd0 ,0,0, e(31,1,0,0), e(31,0,1,1)); // 0 - 1 wraps
        vec[21] = mk(0,1,16'h7FFF,0,5'd0 ,0,0, e(30,1,0,0), e(31,0,1,1)); // 31 + 32767
        vec[22] = mk(0,1,16'h8000,0,5'd0 ,0,0, e(30,1,0,0), e(31,0,1,1)); // 30 - 32768

        // Reset asserted while clock runs.
        reset = 1'b0;
        drive(0,0,16'h0000,0,5'd0,0,0);
        tick();
        tick();
        check("reset_wrap", obs_w, e(0,0,0,0));
        check("reset_nowrap", obs_n, e(0,0,0,0));
        reset = 1'b1;
        #1;
        check("boot_wrap", obs_w, e(0,0,0,0));

        for (int i = 0; i < 23; i++) begin
            drive(vec[i].st, vec[i].br, vec[i].off, vec[i].jp, vec[i].ja, vec[i].hl, vec[i].rs);
            tick();
            check($sformatf("vec%0d_wrap", i), obs_w, vec[i].exp_w);
            check($sformatf("vec%0d_nowrap", i), obs_n, vec[i].exp_n);
        end

        // Resume from fault: restart at START_ADDR through one BOOT cycle.
        drive(0,0,16'h0000,0,5'd0,0,1);
        tick();
        check("fault_resume_boot", obs_n, e(0,0,0,0));
        drive(0,0,16'h0000,0,5'd0,0,0);
        tick();
        check("fault_resume_run", obs_n, e(0,1,0,0));

        // Resume at the top address without wrap faults again.
        drive(0,0,16'h0000,1,5'd31,0,0);
        tick();
        check("jump_top", obs_n, e(31,1,0,0));
        drive(0,0,16'h0000,0,5'd0,1,0);
        tick();
        check("halt_top", obs_n, e(31,0,1,0));
        drive(0,0,16'h0000,0,5'd0,0,1);
        tick();
        check("resume_refault", obs_n, e(31,0,1,1));

        // Negative branch target faults without wrap.
        drive(0,0,16'h0000,0,5'd0,0,1);
        tick();
        check("refault_recover", obs_n, e(0,0,0,0));
        drive(0,0,16'h0000,0,5'd0,0,0);
        tick();
        drive(0,1,16'hFFFF,0,5'd0,0,0);
        tick();
        check("neg_branch_fault", obs_n, e(0,0,1,1));

        // Asynchronous reset in HALT with fault set, between clock edges.
        drive(0,0,16'h0000,0,5'd0,0,0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_nowrap", obs_n, e(0,0,0,0));
        check("async_reset_wrap", obs_w, e(0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_reset_run", obs_n, e(0,1,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_programa.md
Name: contador_programa

Overview:
- Program-counter / fetch-sequencing stage directly upstream of the instruction memory.
- Drives the 5-bit instruction address `direinstru` every cycle.
- Supports sequential fetch, stall, absolute jump, signed relative branch, halt/resume, and out-of-range detection.
- Outputs go straight into the instruction memory address; `fetch_valid` qualifies the instruction word for the decode stage.

Parameters:
- ADDR_W, 5, instruction address width; memory depth = 2^ADDR_W.
- OFF_W, 16, width of the signed two's-complement branch offset (in instruction words).
- START_ADDR, 0, address loaded at reset and on resume-from-fault.
- WRAP_EN, 1, 1 = address arithmetic wraps modulo 2^ADDR_W; 0 = out-of-range address is a fault.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold current address this cycle.
- branch  input  1  take relative branch this cycle.
- branch_off  input  OFF_W  signed offset added to the current `direinstru`.
- jump  input  1  take absolute jump this cycle.
- jump_addr  input  ADDR_W  absolute jump target.
- halt  input  1  enter HALT.
- resume  input  1  leave HALT.
- direinstru  output  ADDR_W  registered instruction address to the instruction memory.
- fetch_valid  output  1  instruction at `direinstru` is valid for decode.
- halted  output  1  state is HALT.
- fault  output  1  sticky: an out-of-range address was computed (only when WRAP_EN=0).

Behaviour:
- **Reset (async, reset=0):**
  - state=BOOT, direinstru=START_ADDR, fetch_valid=0, halted=0, fault=0.
  - Applies immediately, regardless of clk, including mid-branch or in HALT.
- **FSM states:** BOOT, RUN, HALT. All outputs are registered.
- **BOOT:**
  - Lasts exactly one rising edge after reset deasserts. This gives the instruction memory its load cycle.
  - direinstru is held; fetch_valid=0; the next state is RUN.
  - All control inputs are ignored in BOOT.
- **RUN:**
  - fetch_valid=1 except in the cycle after a stall (see the stall rule below).
  - Control priority per edge, highest first:
    1. halt
    2. stall
    3. jump
    4. branch
    5. sequential
  - halt=1 → HALT: direinstru held, fetch_valid=0, halted=1.
  - stall=1 → direinstru held; fetch_valid drops to 0 for the cycle after the stall edge.
  - jump=1 → direinstru=jump_addr. The target is always in range, so it never faults.
  - branch=1 → target = sign-extended branch_off + direinstru.
    - The sum is computed at ADDR_W+OFF_W+1 bits, signed.
  - Otherwise → target = direinstru + 1.
- **Range rule (branch and sequential only):**
  - WRAP_EN=1: direinstru = target mod 2^ADDR_W. Examples: 31+1 → 0; 0 + (−1) → 31.
  - WRAP_EN=0, target < 0 or target > 2^ADDR_W−1:
    - direinstru is held.
    - fault=1 (sticky).
    - State → HALT, halted=1, fetch_valid=0.
- **HALT:**
  - direinstru is held; fetch_valid=0; halted=1.
  - resume=1 with fault=0 → RUN and direinstru+1.
    - The held instruction was already consumed, so execution continues at the next address.
    - With WRAP_EN=0 and direinstru = max address, this re-faults.
  - resume=1 with fault=1 → fault cleared, direinstru=START_ADDR, then BOOT.
  - halt and resume both 1 in HALT → remain in HALT.
  - Only reset clears fault outside HALT.
- **Simultaneous inputs:**
  - jump and branch both 1 → jump wins.
  - stall with jump or branch → the jump/branch is dropped, not deferred. Upstream must re-assert it.
- **Latency:** one cycle from a control input sampled at an edge to the new direinstru.
- **Combinational paths:** no combinational path from any input to any output.

Test Plan:
- Reset and sequential fetch: reset=0 mid-run, release, 6 edges → direinstru 0,0,1,2,3,4; fetch_valid 0,1,1,1,1,1.
- Relative branch: at direinstru=3, branch=1, branch_off=+2 → next direinstru=5. At 5, branch_off=16'hFFFE (−2) → 3.
- Wrap and fault:
  - WRAP_EN=1, run from 30 → 31, 0, 1; fault stays 0.
  - WRAP_EN=0 instance, run from 30 → 31, then HALT with direinstru=31, fault=1, halted=1, fetch_valid=0.
- Priority:
  - At direinstru=4: stall=1, jump=1 (jump_addr=20), branch=1 → direinstru stays 4; fetch_valid=0 next cycle.
  - Next edge with jump=1, branch=1 → 20.
- Halt/resume:
  - halt=1 at direinstru=7 → held at 7, halted=1.
  - resume=1 → 8, fetch_valid=1.
  - Fault case: resume → START_ADDR, one BOOT cycle with fetch_valid=0, fault=0.
- Async reset in HALT with fault=1: reset=0 between edges → direinstru=0, fault=0, halted=0 immediately, without waiting for clk.
